// File: rtl/unidad_control.sv
// Single-cycle ARM-subset control unit: combinational decode of Instr[31:12], plus the NZCV flag register.
// Outputs follow the current instruction and the stored flags; flags change only on clk rising edge or async reset.
module unidad_control (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic [1:0]  RegSrc,
  output logic        RegWrite,
  output logic [1:0]  ImmSrc,
  output logic        ALUSrc,
  output logic [1:0]  ALUControl,
  output logic        MemWrite,
  output logic        MemtoReg,
  output logic        PCSrc
);

  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic       unused_rn;

  assign cond      = Instr[19:16];
  assign op        = Instr[15:14];
  assign funct     = Instr[13:8];
  assign rd        = Instr[3:0];
  assign unused_rn = ^Instr[7:4];

  logic       reg_w, mem_w, branch, alu_op;
  logic [1:0] flag_w;
  logic       cond_ex, pcs;
  logic [3:0] flags_q, flags_d;
  logic       fn, fz, fc, fv;

  assign {fn, fz, fc, fv} = flags_q;

  always_comb begin
    RegSrc   = 2'b00;
    ImmSrc   = 2'b00;
    ALUSrc   = 1'b0;
    MemtoReg = 1'b0;
    reg_w    = 1'b0;
    mem_w    = 1'b0;
    branch   = 1'b0;
    alu_op   = 1'b0;
    case (op)
      2'b00: begin
        ALUSrc = funct[5];
        reg_w  = 1'b1;
        alu_op = 1'b1;
      end
      2'b01: begin
        ImmSrc = 2'b01;
        ALUSrc = 1'b1;
        if (funct[0]) begin
          MemtoReg = 1'b1;
          reg_w    = 1'b1;
        end else begin
          RegSrc = 2'b10;
          mem_w  = 1'b1;
        end
      end
      2'b10: begin
        RegSrc = 2'b01;
        ImmSrc = 2'b10;
        ALUSrc = 1'b1;
        branch = 1'b1;
      end
      default: ;
    endcase
  end

  // C and V are only meaningful for arithmetic, so logical ops leave them alone
  always_comb begin
    ALUControl = 2'b00;
    flag_w     = 2'b00;
    if (alu_op) begin
      case (funct[4:1])
        4'b0100: ALUControl = 2'b00;
        4'b0010: ALUControl = 2'b01;
        4'b0000: ALUControl = 2'b10;
        4'b1100: ALUControl = 2'b11;
        default: ALUControl = 2'b00;
      endcase
      flag_w[1] = funct[0];
      flag_w[0] = funct[0] & ~ALUControl[1];
    end
  end

  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      4'b0000: cond_ex = fz;
      4'b0001: cond_ex = ~fz;
      4'b0010: cond_ex = fc;
      4'b0011: cond_ex = ~fc;
      4'b0100: cond_ex = fn;
      4'b0101: cond_ex = ~fn;
      4'b0110: cond_ex = fv;
      4'b0111: cond_ex = ~fv;
      4'b1000: cond_ex = fc & ~fz;
      4'b1001: cond_ex = ~(fc & ~fz);
      4'b1010: cond_ex = (fn == fv);
      4'b1011: cond_ex = (fn != fv);
      4'b1100: cond_ex = ~fz & (fn == fv);
      4'b1101: cond_ex = ~(~fz & (fn == fv));
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  assign pcs      = ((rd == 4'b1111) & reg_w) | branch;
  assign RegWrite = reg_w & cond_ex;
  assign MemWrite = mem_w & cond_ex;
  assign PCSrc    = pcs & cond_ex;

  always_comb begin
    flags_d = flags_q;
    if (flag_w[1] & cond_ex) flags_d[3:2] = ALUFlags[3:2];
    if (flag_w[0] & cond_ex) flags_d[1:0] = ALUFlags[1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) flags_q <= 4'b0000;
    else        flags_q <= flags_d;
  end

endmodule

// File: tb/tb_unidad_control.sv
// Bench for unidad_control: directed vector table, then random instructions against a reference model.
module tb_unidad_control;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] Instr;
  logic [3:0]  ALUFlags;
  logic [1:0]  RegSrc, ImmSrc, ALUControl;
  logic        RegWrite, ALUSrc, MemWrite, MemtoReg, PCSrc;

  unidad_control dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .RegSrc(RegSrc), .RegWrite(RegWrite), .ImmSrc(ImmSrc), .ALUSrc(ALUSrc),
    .ALUControl(ALUControl), .MemWrite(MemWrite), .MemtoReg(MemtoReg), .PCSrc(PCSrc)
  );

  always #5 clk = ~clk;

  // {RegSrc, RegWrite, ImmSrc, ALUSrc, ALUControl, MemWrite, MemtoReg, PCSrc}
  logic [10:0] dut_out;
  assign dut_out = {RegSrc, RegWrite, ImmSrc, ALUSrc, ALUControl, MemWrite, MemtoReg, PCSrc};

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    logic        rst_n;
    logic [19:0] ins;
    logic [3:0]  alu;
    logic [10:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string n, logic r, logic [19:0] i, logic [3:0] a,
                              logic [1:0] rs, logic rw, logic [1:0] is, logic as,
                              logic [1:0] ac, logic mw, logic mr, logic ps);
    vec_t v;
    v.name = n; v.rst_n = r; v.ins = i; v.alu = a;
    v.exp = {rs, rw, is, as, ac, mw, mr, ps};
    return v;
  endfunction

  task automatic check(string name, logic [10:0] got, logic [10:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%b expected=%b", name, got, exp);
    end
  endtask

  // Reference model: condition test, decode and flag update derived directly from the ISA rules
  logic [3:0] m_flags;

  function automatic logic cond_holds(logic [3:0] c, logic [3:0] f);
    logic n, z, cy, v, base;
    {n, z, cy, v} = f;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: return c == 4'hE;
    endcase
    return c[0] ? !base : base;
  endfunction

  function automatic logic [10:0] model(logic [19:0] ins, logic [3:0] f,
                                        output logic upd_nz, output logic upd_cv);
    logic [1:0] op, rs, is, ac;
    logic [5:0] fn;
    logic ok, rw, mw, as, mr, br, dp;
    op = ins[15:14]; fn = ins[13:8];
    ok = cond_holds(ins[19:16], f);
    rs = 0; is = 0; ac = 0; rw = 0; mw = 0; as = 0; mr = 0; br = 0; dp = 0;
    if (op == 2'd0) begin
      dp = 1; rw = 1; as = fn[5];
      if (fn[4:1] == 4'd2) ac = 2'd1;
      else if (fn[4:1] == 4'd0) ac = 2'd2;
      else if (fn[4:1] == 4'd12) ac = 2'd3;
    end else if (op == 2'd1 && fn[0]) begin
      is = 1; as = 1; mr = 1; rw = 1;
    end else if (op == 2'd1) begin
      rs = 2; is = 1; as = 1; mw = 1;
    end else if (op == 2'd2) begin
      rs = 1; is = 2; as = 1; br = 1;
    end
    upd_nz = dp && fn[0] && ok;
    upd_cv = upd_nz && (ac < 2);
    return {rs, rw && ok, is, as, ac, mw && ok, mr,
            ok && (br || (rw && ins[3:0] == 4'hF))};
  endfunction

  initial begin
    logic        unz, ucv;
    logic [10:0] e;

    reset = 1'b0; Instr = '0; ALUFlags = '0;

    vecs.push_back(mk("rst_add",    0, 20'hE0865, 4'h0, 2'b00,1,2'b00,0,2'b00,0,0,0));
    vecs.push_back(mk("subs_imm",   1, 20'hE2533, 4'h4, 2'b00,1,2'b00,1,2'b01,0,0,0));
    vecs.push_back(mk("beq_taken",  1, 20'h0A000, 4'h0, 2'b01,0,2'b10,1,2'b00,0,0,1));
    vecs.push_back(mk("addne_z1",   1, 20'h10865, 4'h0, 2'b00,0,2'b00,0,2'b00,0,0,0));
    vecs.push_back(mk("beq_in_rst", 0, 20'h0A000, 4'h0, 2'b01,0,2'b10,1,2'b00,0,0,0));
    vecs.push_back(mk("ldr",        1, 20'hE5912, 4'h0, 2'b00,1,2'b01,1,2'b00,0,1,0));
    vecs.push_back(mk("str",        1, 20'hE5812, 4'h0, 2'b10,0,2'b01,1,2'b00,1,0,0));
    vecs.push_back(mk("add_pc",     1, 20'hE081F, 4'h0, 2'b00,1,2'b00,0,2'b00,0,0,1));
    vecs.push_back(mk("orr",        1, 20'hE1810, 4'h0, 2'b00,1,2'b00,0,2'b11,0,0,0));
    vecs.push_back(mk("and",        1, 20'hE0010, 4'h0, 2'b00,1,2'b00,0,2'b10,0,0,0));
    vecs.push_back(mk("ands",       1, 20'hE0110, 4'hF, 2'b00,1,2'b00,0,2'b10,0,0,0));
    vecs.push_back(mk("mi_after",   1, 20'h40865, 4'hF, 2'b00,1,2'b00,0,2'b00,0,0,0));
    vecs.push_back(mk("cs_after",   1, 20'h20865, 4'hF, 2'b00,0,2'b00,0,2'b00,0,0,0));
    vecs.push_back(mk("op11",       1, 20'hEC000, 4'hF, 2'b00,0,2'b00,0,2'b00,0,0,0));
    vecs.push_back(mk("cmp_other",  1, 20'hE1500, 4'h3, 2'b00,1,2'b00,0,2'b00,0,0,0));
    vecs.push_back(mk("cs_c1",      1, 20'h20865, 4'h0, 2'b00,1,2'b00,0,2'b00,0,0,0));
    vecs.push_back(mk("addseq_no",  1, 20'h00965, 4'h4, 2'b00,0,2'b00,0,2'b00,0,0,0));
    vecs.push_back(mk("ne_z_held",  1, 20'h10865, 4'h0, 2'b00,1,2'b00,0,2'b00,0,0,0));
    vecs.push_back(mk("nv_never",   1, 20'hF081F, 4'h0, 2'b00,0,2'b00,0,2'b00,0,0,0));

    // Each vector is driven after a falling edge and checked before the next rising edge
    foreach (vecs[k]) begin
      @(negedge clk);
      reset = vecs[k].rst_n; Instr = vecs[k].ins; ALUFlags = vecs[k].alu;
      #1;
      check(vecs[k].name, dut_out, vecs[k].exp);
    end

    // Asynchronous reset between edges: Z set by SUBS, then cleared with no clock edge
    @(negedge clk);
    reset = 1; Instr = 20'hE2533; ALUFlags = 4'h4;
    @(negedge clk);
    Instr = 20'h0A000; ALUFlags = 4'h0;
    #1 check("beq_z_set", dut_out, 11'b01_0_10_1_00_0_0_1);
    #1 reset = 0;
    #1 check("async_clear", dut_out, 11'b01_0_10_1_00_0_0_0);

    // Random phase: model tracks flags from a known cleared state
    m_flags = 4'h0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      reset    = ($urandom_range(0, 24) != 0);
      Instr    = 20'($urandom);
      ALUFlags = 4'($urandom);
      if (!reset) m_flags = 4'h0;
      #1;
      e = model(Instr, m_flags, unz, ucv);
      check($sformatf("rand%0d_i%05h_f%01h", i, Instr, m_flags), dut_out, e);
      if (reset) begin
        if (unz) m_flags[3:2] = ALUFlags[3:2];
        if (ucv) m_flags[1:0] = ALUFlags[1:0];
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
